// File: rtl/calc_compute_ctrl.sv
// Multi-cycle BCD compute sequencer for the keypad calculator.
// Optional integer divide on operator 13 when CALC_DIV_EN is defined.
module calc_compute_ctrl #(
  parameter logic [3:0] BLANK = 4'd15,
  parameter logic [3:0] MINUS = 4'd11,
  parameter logic [3:0] ERRC  = 4'd14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a1,
  input  logic [3:0] a0,
  input  logic [3:0] b1,
  input  logic [3:0] b0,
  input  logic [3:0] operator,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] digit7,
  output logic [3:0] digit6,
  output logic [3:0] digit5,
  output logic [3:0] digit4
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_CONV, S_FMT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] nib_q, nib_d;
  logic [3:0]  op_q, op_d;
  logic [6:0]  a_q, a_d, b_q, b_d;
  logic [13:0] mag_q, mag_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        errf_q, errf_d;
  logic        err_q, err_d;
  logic [15:0] dig_q, dig_d;

  logic [6:0]  a_bin, b_bin;
  logic        nib_bad, op_ok;
  logic        is_add, is_sub, is_mul, is_div;
  logic [15:0] bcd_adj;
  logic [3:0]  f3, f2, f1, f0;
  logic        z3, z2, z1;
  logic [7:0]  b_ext;

`ifdef CALC_DIV_EN
  logic [7:0]  rem_q, rem_d, rem_try;
  logic [6:0]  quo_q, quo_d;
  logic        ge;
`endif

  assign a_bin = {3'b0, nib_q[15:12]} * 7'd10 + {3'b0, nib_q[11:8]};
  assign b_bin = {3'b0, nib_q[7:4]} * 7'd10 + {3'b0, nib_q[3:0]};
  assign nib_bad = (nib_q[15:12] > 4'd9) | (nib_q[11:8] > 4'd9) |
                   (nib_q[7:4] > 4'd9) | (nib_q[3:0] > 4'd9);
  assign is_add = (op_q == 4'd10);
  assign is_sub = (op_q == 4'd11);
  assign is_mul = (op_q == 4'd12);
`ifdef CALC_DIV_EN
  assign is_div = (op_q == 4'd13);
  assign op_ok  = is_add | is_sub | is_mul | (is_div & (b_bin != 7'd0));
  assign rem_try = {rem_q[6:0], quo_q[6]};
  assign ge = (rem_try >= b_ext);
`else
  assign is_div = 1'b0;
  assign op_ok  = is_add | is_sub | is_mul;
`endif
  assign b_ext = {1'b0, b_q};

  // Double-dabble add-3 correction on every BCD digit before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking and minus placement for the final digits
  always_comb begin
    z3 = (bcd_q[15:12] == 4'd0);
    z2 = z3 & (bcd_q[11:8] == 4'd0);
    z1 = z2 & (bcd_q[7:4] == 4'd0);
    f3 = z3 ? BLANK : bcd_q[15:12];
    f2 = z2 ? BLANK : bcd_q[11:8];
    f1 = z1 ? BLANK : bcd_q[7:4];
    f0 = bcd_q[3:0];
    if (neg_q) begin
      if (z1) f1 = MINUS;
      else    f2 = MINUS;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    errf_d  = errf_q;
    err_d   = err_q;
    dig_d   = dig_q;
`ifdef CALC_DIV_EN
    rem_d   = rem_q;
    quo_d   = quo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nib_d   = {a1, a0, b1, b0};
          op_d    = operator;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        a_d    = a_bin;
        b_d    = b_bin;
        mag_d  = 14'd0;
        bcd_d  = 16'd0;
        cnt_d  = 4'd0;
        neg_d  = 1'b0;
        errf_d = nib_bad | ~op_ok;
`ifdef CALC_DIV_EN
        rem_d  = 8'd0;
        quo_d  = a_bin;
`endif
        state_d = (nib_bad | ~op_ok) ? S_FMT : S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_add: begin
            mag_d   = {7'b0, a_q} + {7'b0, b_q};
            state_d = S_CONV;
          end
          is_sub: begin
            mag_d   = (a_q < b_q) ? {7'b0, b_q - a_q} : {7'b0, a_q - b_q};
            neg_d   = (a_q < b_q);
            state_d = S_CONV;
          end
          is_mul: begin
            if (b_ext[cnt_q[2:0]])
              mag_d = mag_q + ({7'b0, a_q} << cnt_q[2:0]);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd6) begin
              cnt_d   = 4'd0;
              state_d = S_CONV;
            end
          end
`ifdef CALC_DIV_EN
          is_div: begin
            rem_d = ge ? rem_try - b_ext : rem_try;
            quo_d = {quo_q[5:0], ge};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd6) begin
              mag_d   = {7'b0, quo_q[5:0], ge};
              cnt_d   = 4'd0;
              state_d = S_CONV;
            end
          end
`endif
          default: state_d = S_FMT;
        endcase
      end
      S_CONV: begin
        bcd_d = {bcd_adj[14:0], mag_q[13]};
        mag_d = {mag_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          cnt_d   = 4'd0;
          state_d = S_FMT;
        end
      end
      S_FMT: begin
        if (errf_q) begin
          dig_d = {BLANK, BLANK, BLANK, ERRC};
          err_d = 1'b1;
        end else begin
          dig_d = {f3, f2, f1, f0};
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nib_q   <= 16'd0;
      op_q    <= 4'd0;
      a_q     <= 7'd0;
      b_q     <= 7'd0;
      mag_q   <= 14'd0;
      bcd_q   <= 16'd0;
      cnt_q   <= 4'd0;
      neg_q   <= 1'b0;
      errf_q  <= 1'b0;
      err_q   <= 1'b0;
      dig_q   <= {BLANK, BLANK, BLANK, BLANK};
`ifdef CALC_DIV_EN
      rem_q   <= 8'd0;
      quo_q   <= 7'd0;
`endif
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      errf_q  <= errf_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
`ifdef CALC_DIV_EN
      rem_q   <= rem_d;
      quo_q   <= quo_d;
`endif
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign digit7 = dig_q[15:12];
  assign digit6 = dig_q[11:8];
  assign digit5 = dig_q[7:4];
  assign digit4 = dig_q[3:0];

endmodule

// File: tb/tb_calc_compute_ctrl.sv
// Randomized self-checking bench for calc_compute_ctrl.
// Reference model follows CALC_DIV_EN the same way the design does.
module tb_calc_compute_ctrl;

  logic       clk, rst_n, start;
  logic [3:0] a1, a0, b1, b0, operator;
  logic       busy, done, err;
  logic [3:0] digit7, digit6, digit5, digit4;

  int n_chk = 0;
  int n_err = 0;

  calc_compute_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .operator(operator),
    .busy(busy), .done(done), .err(err),
    .digit7(digit7), .digit6(digit6),
    .digit5(digit5), .digit4(digit4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digs();
    return {digit7, digit6, digit5, digit4};
  endfunction

  task automatic model(input int xa1, xa0, xb1, xb0, op,
                       output logic [15:0] dig,
                       output bit e, output int lat);
    int va, vb, v, ms;
    bit neg, ok;
    int d[4];
    va = xa1 * 10 + xa0;
    vb = xb1 * 10 + xb0;
    ok = (xa1 < 10) && (xa0 < 10) && (xb1 < 10) && (xb0 < 10);
    neg = 0;
    v = 0;
    lat = 17;
    case (op)
      10: v = va + vb;
      11: begin
        v = (va < vb) ? vb - va : va - vb;
        neg = (va < vb);
      end
      12: begin v = va * vb; lat = 23; end
`ifdef CALC_DIV_EN
      13: begin
        if (vb == 0) ok = 0;
        else v = va / vb;
        lat = 23;
      end
`endif
      default: ok = 0;
    endcase
    if (!ok) begin
      dig = 16'hFFFE;
      e = 1;
      lat = 2;
      return;
    end
    e = 0;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    ms = 0;
    for (int i = 0; i < 4; i++)
      if (d[i] != 0) ms = i;
    for (int i = 0; i < 4; i++)
      if (i > ms) d[i] = 15;
    if (neg) d[ms + 1] = 11;
    dig = {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
  endtask

  task automatic run(input int xa1, xa0, xb1, xb0, op);
    logic [15:0] edig;
    bit ee;
    int elat, glat;
    model(xa1, xa0, xb1, xb0, op, edig, ee, elat);
    @(negedge clk);
    a1 = 4'(xa1); a0 = 4'(xa0);
    b1 = 4'(xb1); b0 = 4'(xb0);
    operator = 4'(op);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a1 = 4'($urandom); a0 = 4'($urandom);
    b1 = 4'($urandom); b0 = 4'($urandom);
    operator = 4'($urandom);
    glat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        glat = n;
        break;
      end
    end
    check("latency", glat, elat);
    check("digits", digs(), edig);
    check("err", err, ee);
    @(posedge clk);
    #1;
    check("busy_after", busy, 1'b0);
    check("done_pulse", done, 1'b0);
    check("digits_hold", digs(), edig);
    check("err_hold", err, ee);
  endtask

  initial begin
    int dcnt, dat;
    rst_n = 1'b0; start = 1'b0;
    a1 = 0; a0 = 0; b1 = 0; b0 = 0; operator = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_digits", digs(), 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    run(1, 2, 3, 4, 10);
    run(0, 5, 1, 2, 11);
    run(1, 2, 0, 5, 11);
    run(9, 9, 9, 9, 12);
    run(0, 0, 3, 7, 12);
    run(1, 2, 3, 4, 14);
    run(1, 10, 3, 4, 10);
    run(4, 4, 4, 4, 11);
    run(8, 4, 1, 2, 13);
    run(8, 4, 0, 0, 13);
    run(0, 0, 0, 0, 10);

    // start pulsed during a multiply is ignored
    @(negedge clk);
    a1 = 9; a0 = 9; b1 = 9; b0 = 9; operator = 12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcnt = 0; dat = 0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin
        a1 = 0; a0 = 1; b1 = 0; b0 = 1; operator = 10;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (n == 5) start = 1'b0;
      if (done) begin
        dcnt++;
        if (dat == 0) dat = n;
      end
    end
    check("busy_start_cnt", dcnt, 1);
    check("busy_start_lat", dat, 23);
    check("busy_start_dig", digs(), 16'h9801);

    // reset during CONV aborts without done
    @(negedge clk);
    a1 = 1; a0 = 2; b1 = 3; b0 = 4; operator = 10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_digits", digs(), 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("abort_nodone", dcnt, 0);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      int r[4];
      int op;
      for (int k = 0; k < 4; k++)
        r[k] = ($urandom_range(0, 15) == 0) ?
               $urandom_range(10, 15) : $urandom_range(0, 9);
      op = ($urandom_range(0, 7) == 0) ?
           $urandom_range(13, 15) : $urandom_range(10, 13);
      run(r[0], r[1], r[2], r[3], op);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
